// File: rtl/alu_flags_addr_unit.sv
// Execute stage: condition check, operand-2 shifter, ALU, NZCV register, RAM address mux.
// Latency: datapath combinational, flags one cycle; backpressure: none, one operation per cycle.
module alu_flags_addr_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] in1,
    input  logic [31:0] in2,
    input  logic        sbit,
    input  logic [3:0]  cond,
    input  logic [3:0]  opcode,
    input  logic [2:0]  srcontrol,
    input  logic [15:0] imvalue,
    input  logic        sel_add_bus,
    input  logic [15:0] address_add_bus_in,
    input  logic [7:0]  pc_addr,
    output logic [31:0] result,
    output logic        cond_pass,
    output logic [3:0]  flags,
    output logic [15:0] address_add_bus_out
);

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } nzcv_t;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_MUL  = 4'h2;
    localparam logic [3:0] OP_ORR  = 4'h3;
    localparam logic [3:0] OP_AND  = 4'h4;
    localparam logic [3:0] OP_EOR  = 4'h5;
    localparam logic [3:0] OP_MOV  = 4'h6;
    localparam logic [3:0] OP_MOVI = 4'h7;
    localparam logic [3:0] OP_CMP  = 4'h8;
    localparam logic [3:0] OP_LDR  = 4'h9;
    localparam logic [3:0] OP_STR  = 4'hA;

    nzcv_t       flags_q;
    nzcv_t       flags_nxt;
    logic        cond_ok;
    logic [31:0] op2;
    logic        sh_carry;
    logic [32:0] sum;
    logic [32:0] diff;
    logic [31:0] prod;
    logic [31:0] alu_raw;
    logic        flag_we;

    always_comb begin
        cond_ok = 1'b0;
        case (cond)
            4'h0: cond_ok = flags_q.z;
            4'h1: cond_ok = !flags_q.z;
            4'h2: cond_ok = flags_q.c;
            4'h3: cond_ok = !flags_q.c;
            4'h4: cond_ok = flags_q.n;
            4'h5: cond_ok = !flags_q.n;
            4'h6: cond_ok = flags_q.v;
            4'h7: cond_ok = !flags_q.v;
            4'h8: cond_ok = flags_q.c && !flags_q.z;
            4'h9: cond_ok = !flags_q.c || flags_q.z;
            4'hA: cond_ok = (flags_q.n == flags_q.v);
            4'hB: cond_ok = (flags_q.n != flags_q.v);
            4'hC: cond_ok = !flags_q.z && (flags_q.n == flags_q.v);
            4'hD: cond_ok = flags_q.z || (flags_q.n != flags_q.v);
            4'hE: cond_ok = 1'b1;
            default: cond_ok = 1'b0;
        endcase
    end

    // Shifter carry is the last bit pushed out; no shift passes the live C through.
    always_comb begin
        op2      = in2;
        sh_carry = flags_q.c;
        case (srcontrol)
            3'd1: begin op2 = {in2[30:0], 1'b0};       sh_carry = in2[31]; end
            3'd2: begin op2 = {1'b0, in2[31:1]};       sh_carry = in2[0];  end
            3'd3: begin op2 = {in2[31], in2[31:1]};    sh_carry = in2[0];  end
            3'd4: begin op2 = {in2[0], in2[31:1]};     sh_carry = in2[0];  end
            3'd5: begin op2 = {in2[23:0], 8'h00};      sh_carry = in2[24]; end
            3'd6: begin op2 = {8'h00, in2[31:8]};      sh_carry = in2[7];  end
            3'd7: begin op2 = {in2[7:0], in2[31:8]};   sh_carry = in2[7];  end
            default: begin op2 = in2;                  sh_carry = flags_q.c; end
        endcase
    end

    assign sum  = {1'b0, in1} + {1'b0, op2};
    assign diff = {1'b0, in1} - {1'b0, op2};
    assign prod = in1 * op2;

    always_comb begin
        alu_raw = 32'h0;
        case (opcode)
            OP_ADD:         alu_raw = sum[31:0];
            OP_SUB, OP_CMP: alu_raw = diff[31:0];
            OP_MUL:         alu_raw = prod;
            OP_ORR:         alu_raw = in1 | op2;
            OP_AND:         alu_raw = in1 & op2;
            OP_EOR:         alu_raw = in1 ^ op2;
            OP_MOV:         alu_raw = op2;
            OP_MOVI:        alu_raw = {16'h0000, imvalue};
            OP_LDR, OP_STR: alu_raw = in1;
            default:        alu_raw = 32'h0;
        endcase
    end

    always_comb begin
        flags_nxt   = flags_q;
        flags_nxt.n = alu_raw[31];
        flags_nxt.z = (alu_raw == 32'h0);
        case (opcode)
            OP_ADD: begin
                flags_nxt.c = sum[32];
                flags_nxt.v = (in1[31] == op2[31]) && (sum[31] != in1[31]);
            end
            OP_SUB, OP_CMP: begin
                flags_nxt.c = !diff[32];
                flags_nxt.v = (in1[31] != op2[31]) && (diff[31] != in1[31]);
            end
            OP_ORR, OP_AND, OP_EOR, OP_MOV: flags_nxt.c = sh_carry;
            default: flags_nxt.c = flags_q.c;
        endcase
    end

    assign flag_we = cond_ok && (sbit || (opcode == OP_CMP)) && (opcode <= OP_CMP);

    always_ff @(posedge clk) begin
        if (reset) begin
            flags_q <= '0;
        end else if (flag_we) begin
            flags_q <= flags_nxt;
        end
    end

    assign cond_pass           = cond_ok;
    assign result              = cond_ok ? alu_raw : 32'h0;
    assign flags               = flags_q;
    assign address_add_bus_out = sel_add_bus ? address_add_bus_in : {8'h00, pc_addr};

endmodule

// File: tb/tb_alu_flags_addr_unit.sv
module tb_alu_flags_addr_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] in1, in2;
    logic        sbit;
    logic [3:0]  cond, opcode;
    logic [2:0]  srcontrol;
    logic [15:0] imvalue;
    logic        sel_add_bus;
    logic [15:0] address_add_bus_in;
    logic [7:0]  pc_addr;
    logic [31:0] result;
    logic        cond_pass;
    logic [3:0]  flags;
    logic [15:0] address_add_bus_out;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_flags_addr_unit dut (
        .clk                 (clk),
        .reset               (reset),
        .in1                 (in1),
        .in2                 (in2),
        .sbit                (sbit),
        .cond                (cond),
        .opcode              (opcode),
        .srcontrol           (srcontrol),
        .imvalue             (imvalue),
        .sel_add_bus         (sel_add_bus),
        .address_add_bus_in  (address_add_bus_in),
        .pc_addr             (pc_addr),
        .result              (result),
        .cond_pass           (cond_pass),
        .flags               (flags),
        .address_add_bus_out (address_add_bus_out)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [3:0] c, input logic [3:0] o, input logic s,
                         input logic [2:0] sr, input logic [31:0] a, input logic [31:0] b,
                         input logic [15:0] imm);
        cond = c; opcode = o; sbit = s; srcontrol = sr; in1 = a; in2 = b; imvalue = imm;
        #1;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        sel_add_bus = 1'b0; address_add_bus_in = 16'h0; pc_addr = 8'h0;
        drive(4'hE, 4'h0, 1'b0, 3'd0, 32'h0, 32'h0, 16'h0);
        tick; tick;
        chk("reset_flags", {28'h0, flags}, 32'h0);
        reset = 1'b0;

        drive(4'hC, 4'h0, 1'b0, 3'd0, 32'd1, 32'd1, 16'h0);
        chk("gt_after_reset", {31'h0, cond_pass}, 32'd1);
        drive(4'hB, 4'h0, 1'b0, 3'd0, 32'd1, 32'd1, 16'h0);
        chk("lt_after_reset", {31'h0, cond_pass}, 32'd0);
        drive(4'h0, 4'h0, 1'b0, 3'd0, 32'd1, 32'd1, 16'h0);
        chk("eq_after_reset_res", result, 32'h0);

        drive(4'hE, 4'h0, 1'b1, 3'd0, 32'h7FFFFFFF, 32'd1, 16'h0);
        chk("add_ovf_res", result, 32'h80000000);
        tick;
        chk("add_ovf_flags", {28'h0, flags}, 32'h9);
        drive(4'hA, 4'h6, 1'b0, 3'd0, 32'h0, 32'h0, 16'h0);
        chk("ge_n_eq_v", {31'h0, cond_pass}, 32'd1);

        drive(4'hE, 4'h8, 1'b0, 3'd0, 32'd5, 32'd5, 16'h0);
        tick;
        chk("cmp_flags", {28'h0, flags}, 32'h6);
        drive(4'h0, 4'h0, 1'b0, 3'd0, 32'd2, 32'd3, 16'h0);
        chk("add_eq_res", result, 32'd5);
        chk("add_eq_pass", {31'h0, cond_pass}, 32'd1);
        tick;
        drive(4'h1, 4'h0, 1'b1, 3'd0, 32'd2, 32'd3, 16'h0);
        chk("add_ne_res", result, 32'h0);
        chk("add_ne_pass", {31'h0, cond_pass}, 32'd0);
        tick;
        chk("add_ne_flags_hold", {28'h0, flags}, 32'h6);

        drive(4'hE, 4'h1, 1'b1, 3'd0, 32'd0, 32'd1, 16'h0);
        chk("sub_res", result, 32'hFFFFFFFF);
        tick;
        chk("sub_flags", {28'h0, flags}, 32'h8);
        drive(4'hE, 4'h0, 1'b0, 3'd0, 32'hFFFFFFFF, 32'd1, 16'h0);
        chk("add_nos_res", result, 32'h0);
        tick;
        chk("add_nos_flags", {28'h0, flags}, 32'h8);

        drive(4'hE, 4'h6, 1'b1, 3'd1, 32'h0, 32'h80000001, 16'h0);
        chk("mov_lsl1", result, 32'h00000002);
        tick;
        chk("mov_lsl1_flags", {28'h0, flags}, 32'h2);
        drive(4'hE, 4'h6, 1'b1, 3'd3, 32'h0, 32'h80000001, 16'h0);
        chk("mov_asr1", result, 32'hC0000000);
        tick;
        chk("mov_asr1_flags", {28'h0, flags}, 32'hA);
        drive(4'hE, 4'h6, 1'b1, 3'd2, 32'h0, 32'h80000001, 16'h0);
        chk("mov_lsr1", result, 32'h40000000);
        tick;
        chk("mov_lsr1_flags", {28'h0, flags}, 32'h2);
        drive(4'hE, 4'h7, 1'b1, 3'd7, 32'h0, 32'h80000001, 16'hBEEF);
        chk("movi", result, 32'h0000BEEF);
        tick;
        chk("movi_keeps_c", {28'h0, flags}, 32'h2);
        drive(4'hE, 4'h6, 1'b1, 3'd7, 32'h0, 32'h80000001, 16'h0);
        chk("mov_ror8", result, 32'h01800000);
        tick;
        chk("mov_ror8_flags", {28'h0, flags}, 32'h0);

        drive(4'hE, 4'h0, 1'b1, 3'd0, 32'h7FFFFFFF, 32'd1, 16'h0);
        tick;
        drive(4'hE, 4'h2, 1'b1, 3'd0, 32'h00010000, 32'h00010000, 16'h0);
        chk("mul_res", result, 32'h0);
        tick;
        chk("mul_flags", {28'h0, flags}, 32'h5);
        drive(4'hE, 4'h2, 1'b0, 3'd0, 32'd7, 32'd6, 16'h0);
        chk("mul_small", result, 32'd42);

        drive(4'hE, 4'h9, 1'b1, 3'd0, 32'hDEADBEEF, 32'h1, 16'h0);
        chk("ldr_res", result, 32'hDEADBEEF);
        tick;
        chk("ldr_flags_hold", {28'h0, flags}, 32'h5);
        drive(4'hE, 4'hB, 1'b1, 3'd0, 32'hDEADBEEF, 32'h1, 16'h0);
        chk("op_b_res", result, 32'h0);
        drive(4'hF, 4'h3, 1'b1, 3'd0, 32'hF0F0F0F0, 32'h0F0F0F0F, 16'h0);
        chk("nv_res", result, 32'h0);
        drive(4'hE, 4'h3, 1'b0, 3'd0, 32'hF0F0F0F0, 32'h0F0F0F0F, 16'h0);
        chk("orr_res", result, 32'hFFFFFFFF);
        drive(4'hE, 4'h5, 1'b0, 3'd0, 32'hFF00FF00, 32'h0FF00FF0, 16'h0);
        chk("eor_res", result, 32'hF0F0F0F0);

        sel_add_bus = 1'b0; pc_addr = 8'hA5; address_add_bus_in = 16'h1234;
        #1;
        chk("addr_pc", {16'h0, address_add_bus_out}, 32'h000000A5);
        sel_add_bus = 1'b1;
        #1;
        chk("addr_bus", {16'h0, address_add_bus_out}, 32'h00001234);

        reset = 1'b1;
        drive(4'hE, 4'h0, 1'b1, 3'd0, 32'h7FFFFFFF, 32'd1, 16'h0);
        chk("reset_comb_res", result, 32'h80000000);
        tick;
        chk("reset_over_update", {28'h0, flags}, 32'h0);
        reset = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
